sha3_digest_serializer: RTL and testbench
=========================================

// Module: sha3_digest_serializer
// PURPOSE
//  Downstream of the Keccak-f[1600] permutation stage. Captures the final 1600-bit state on pushin.
//  Extracts the SHA3-256 digest (first DIGEST_LANES lanes) plus its 8-bit tag.
//  Emits the digest as 64-bit words with valid/stall flow control.
//  A DEPTH-entry digest buffer decouples the 8-cycle permutation cadence from a stalling consumer.
// PARAMETERS
//  LANE_W        64  bits per Keccak lane / output word
//  DIGEST_LANES  4   lanes emitted per digest (4 = SHA3-256)
//  TAG_W         8   tag width, carried unchanged
//  DEPTH         2   buffered digests (power of 2, >=2)
// PORTS
//  clk      input   1               rising-edge clock
//  reset    input   1               asynchronous, active-low
//  pushin   input   1               din/tagin valid this cycle (permutation pushout)
//  din      input   1600            state; lane (x,y) = din[64*(5*y+x) +: 64]
//  tagin    input   TAG_W           tag of this state
//  stopout  output  1               buffer full; upstream must hold result
//  dout     output  LANE_W          current digest word
//  dix      output  log2(DIGEST_LANES)  word index within digest, 0 first
//  tagout   output  TAG_W           tag of digest being sent
//  pushout  output  1               dout/dix/tagout valid
//  lastout  output  1               pushout && dix==DIGEST_LANES-1
//  stopin   input   1               consumer stall; word held while high
//  overflow output  1               sticky: pushin dropped while full
// BEHAVIOUR
//  - Reset (async assert, sync release): buffer empty, count=0, dix=0; pushout, lastout, stopout,
//    overflow, dout and tagout all 0.
//  - Write: pushin && (count<DEPTH || pop this cycle) stores lanes (0,0)..(DIGEST_LANES-1,0) + tagin at wr_ptr.
//  - Word accept = pushout && !stopin; dix increments on accept.
//  - Digest pop = accept with dix==DIGEST_LANES-1: dix->0, rd_ptr++, count--.
//  - Push+pop in the same cycle: count unchanged, both take effect, also when full.
//  - Drop: pushin && full && no pop. Data is discarded, overflow<=1 until reset, no other state changes.
//  - Control FSM: IDLE (count==0, pushout=0) -> SEND on write.
//    SEND -> IDLE on pop when count==1 and no simultaneous write; otherwise stays SEND.
//  - Latency: pushin at edge n into empty buffer -> pushout=1, dix=0, word 0 valid after edge n.
//    Unstalled digest takes DIGEST_LANES cycles; back-to-back digests emit with no bubble.
//  - Outputs are registered. dout/tagout/dix hold stable while stopin=1 (no change under stall).
//  - stopout = (count==DEPTH), registered; a pop in the same cycle still accepts pushin.
//  - Pointers wrap modulo DEPTH. dix wraps DIGEST_LANES-1 -> 0 only on pop.
//  - Reset mid-digest: partial digest and all buffered entries discarded, no further pushout.
// CONFIGURATION
//  SHA3_DIGEST_BYTESWAP_EN defined: each dout word is byte-reversed (byte0 in dout[63:56]).
//    This gives big-endian hex-order digest output.
//  Undefined: dout carries lane bits unmodified (Keccak little-endian lane order).
//    Storage and timing are identical in both builds.
// STRUCTURE
//  sha3_pkg: LANE_W, STATE_W=1600, lane_idx(x,y)=5*y+x, DIGEST256_LANES=4, byteswap64 function.
//  Sub-module digest_fifo: DEPTH x (DIGEST_LANES*LANE_W+TAG_W) storage, pointers, count, full/empty.
//  Top level holds the FSM, dix counter, output mux and overflow flag.
// TESTING
//  1 Reset low mid-run -> all outputs 0 within the same cycle. After release, idle with pushout=0.
//  2 Push state with lane(x,0)=64'h0123456789ABCDE0+x, tag 8'h5A, stopin=0
//    -> 4 consecutive words ...E0..E3, dix 0..3, tagout 5A, lastout on dix=3.
//  3 Same digest with stopin=1 during dix=1 for 3 cycles -> word ...E1 held 4 cycles, no skip or duplicate.
//  4 Three pushes 1 cycle apart with stopin=1 -> stopout=1 after 2nd, 3rd dropped, overflow=1.
//    Release stall -> exactly two digests out.
//  5 Full buffer; pushin on the cycle of the pop (dix=3 accepted) -> accepted, count stays 2, overflow stays 0.
//  6 Build with SHA3_DIGEST_BYTESWAP_EN, lane0=64'h0011223344556677 -> dout=64'h7766554433221100.

Source files
------------

// File: rtl/sha3_digest_serializer_pkg.sv
// Shared definitions for the SHA3 digest serializer slice.
// Contents: Keccak lane/state geometry, lane index helper, control state
// encoding and the 64-bit byte-reversal helper used by the byteswap build.
package sha3_digest_serializer_pkg;

    localparam int SHA3_LANE_W     = 64;
    localparam int SHA3_STATE_W    = 1600;
    localparam int DIGEST256_LANES = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ctrl_state_e;

    // Keccak lane (x,y) lives at lane slot 5*y+x of the flattened state.
    function automatic int lane_idx(input int x, input int y);
        return 5 * y + x;
    endfunction

    // Reverse byte order so byte 0 lands in bits [63:56].
    function automatic logic [63:0] byteswap64(input logic [63:0] w);
        logic [63:0] r;
        r = 64'h0;
        for (int b = 0; b < 8; b++) begin
            r[(7 - b) * 8 +: 8] = w[b * 8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sha3_digest_serializer_if.sv
// Handshake bundle between the permutation stage, the serializer and the
// digest consumer.
//   pushin/din/tagin/stopout : state capture side
//   dout/dix/tagout/pushout/lastout/stopin : word output side
//   overflow : sticky drop indicator
// modport slave is the serializer side, modport master the surrounding logic.
interface sha3_digest_serializer_if
    import sha3_digest_serializer_pkg::*;
#(
    parameter int LANE_W  = SHA3_LANE_W,
    parameter int DIX_W   = 2,
    parameter int TAG_W   = 8,
    parameter int STATE_W = SHA3_STATE_W
);
    logic               pushin;
    logic [STATE_W-1:0] din;
    logic [TAG_W-1:0]   tagin;
    logic               stopout;
    logic [LANE_W-1:0]  dout;
    logic [DIX_W-1:0]   dix;
    logic [TAG_W-1:0]   tagout;
    logic               pushout;
    logic               lastout;
    logic               stopin;
    logic               overflow;

    modport master (
        output pushin, din, tagin, stopin,
        input  stopout, dout, dix, tagout, pushout, lastout, overflow
    );

    modport slave (
        input  pushin, din, tagin, stopin,
        output stopout, dout, dix, tagout, pushout, lastout, overflow
    );
endinterface

// File: rtl/sha3_digest_serializer_fifo.sv
// Digest buffer: DEPTH entries of packed {tag, lanes}.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   wr_en, wr_data  store one entry at the write pointer
//   pop             retire the head entry
//   head_data       entry at the read pointer
//   next_data       entry behind the head (valid when count >= 2)
//   count           occupancy, count_next its value after this edge
//   full, empty     occupancy flags
// The caller guarantees wr_en only when not full or popping, and pop only
// when not empty. DEPTH must be a power of two so pointers wrap naturally.
module sha3_digest_serializer_fifo #(
    parameter  int ENTRY_W = 264,
    parameter  int DEPTH   = 2,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head_data,
    output logic [ENTRY_W-1:0] next_data,
    output logic [CNT_W-1:0]   count,
    output logic [CNT_W-1:0]   count_next,
    output logic               full,
    output logic               empty
);

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_inc_s;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_next_s;

    // Occupancy after this edge; simultaneous push and pop leave it unchanged.
    always_comb begin
        rd_ptr_inc_s = rd_ptr_r + PTR_W'(1'b1);
        count_next_s = count_r;
        case ({wr_en, pop})
            2'b10:   count_next_s = count_r + CNT_W'(1'b1);
            2'b01:   count_next_s = count_r - CNT_W'(1'b1);
            default: count_next_s = count_r;
        endcase
    end

    // Storage, pointers and occupancy counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr_en) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_inc_s;
            end
            count_r <= count_next_s;
        end
    end

    assign head_data  = mem_r[rd_ptr_r];
    assign next_data  = mem_r[rd_ptr_inc_s];
    assign count      = count_r;
    assign count_next = count_next_s;
    assign full       = (count_r == CNT_W'(DEPTH));
    assign empty      = (count_r == CNT_W'(0));

endmodule

// File: rtl/sha3_digest_serializer.sv
// SHA3 digest serializer: captures the final Keccak state on pushin, keeps
// lanes (0,0)..(DIGEST_LANES-1,0) plus the tag in a DEPTH-entry buffer and
// streams them as LANE_W words under valid/stall flow control.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    sha3_digest_serializer_if.slave (pushin/din/tagin/stopout,
//          dout/dix/tagout/pushout/lastout/stopin, overflow)
// Build option: define SHA3_DIGEST_BYTESWAP_EN to byte-reverse every output
// word (big-endian hex-order digest). Storage and timing do not change.
// All outputs are registered. The output registers are loaded from the
// buffer contents as they will be after the current edge, so a push into an
// empty buffer shows word 0 right after that edge and consecutive digests
// follow without a bubble.
module sha3_digest_serializer
    import sha3_digest_serializer_pkg::*;
#(
    parameter int LANE_W       = SHA3_LANE_W,
    parameter int DIGEST_LANES = DIGEST256_LANES,
    parameter int TAG_W        = 8,
    parameter int DEPTH        = 2
) (
    input logic                   clk,
    input logic                   reset,
    sha3_digest_serializer_if.slave bus
);

    localparam int ENTRY_W = DIGEST_LANES * LANE_W + TAG_W;
    localparam int DIX_W   = (DIGEST_LANES > 1) ? $clog2(DIGEST_LANES) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam logic [DIX_W-1:0] DIX_LAST = DIX_W'(DIGEST_LANES - 1);

    ctrl_state_e        state_r;
    logic [DIX_W-1:0]   dix_r;
    logic [LANE_W-1:0]  dout_r;
    logic [TAG_W-1:0]   tagout_r;
    logic               pushout_r;
    logic               lastout_r;
    logic               stopout_r;
    logic               overflow_r;

    logic [ENTRY_W-1:0] wr_entry_s;
    logic [ENTRY_W-1:0] head_s;
    logic [ENTRY_W-1:0] next_s;
    logic [ENTRY_W-1:0] head_next_s;
    logic [CNT_W-1:0]   count_s;
    logic [CNT_W-1:0]   count_next_s;
    logic               full_s;
    logic               empty_s;
    logic               accept_s;
    logic               pop_s;
    logic               wr_en_s;
    logic               drop_s;
    logic               send_next_s;
    logic [DIX_W-1:0]   dix_next_s;
    logic [LANE_W-1:0]  lane_sel_s;
    logic [LANE_W-1:0]  word_next_s;

    // Gather the digest lanes of row y=0 and the tag into one buffer entry.
    always_comb begin
        wr_entry_s = '0;
        for (int x = 0; x < DIGEST_LANES; x++) begin
            wr_entry_s[x * LANE_W +: LANE_W] = bus.din[lane_idx(x, 0) * LANE_W +: LANE_W];
        end
        wr_entry_s[DIGEST_LANES * LANE_W +: TAG_W] = bus.tagin;
    end

    // Handshake decode: a pop frees a slot in the same cycle, so a full
    // buffer still takes pushin when the last word is being accepted.
    always_comb begin
        accept_s = pushout_r && !bus.stopin;
        pop_s    = accept_s && (dix_r == DIX_LAST);
        wr_en_s  = bus.pushin && (!full_s || pop_s);
        drop_s   = bus.pushin && full_s && !pop_s;
    end

    sha3_digest_serializer_fifo #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_digest_fifo (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en_s),
        .wr_data    (wr_entry_s),
        .pop        (pop_s),
        .head_data  (head_s),
        .next_data  (next_s),
        .count      (count_s),
        .count_next (count_next_s),
        .full       (full_s),
        .empty      (empty_s)
    );

    // Head entry as it will be after this edge. When the buffer is about to
    // hold only the incoming entry, it is forwarded straight from the input.
    always_comb begin
        head_next_s = head_s;
        if (pop_s) begin
            if (count_s > CNT_W'(1'b1)) begin
                head_next_s = next_s;
            end else begin
                head_next_s = wr_entry_s;
            end
        end else if (empty_s) begin
            head_next_s = wr_entry_s;
        end else begin
            head_next_s = head_s;
        end
    end

    // Word index and output word for the next cycle.
    always_comb begin
        send_next_s = (count_next_s != CNT_W'(0));
        dix_next_s  = dix_r;
        if (pop_s) begin
            dix_next_s = '0;
        end else if (accept_s) begin
            dix_next_s = dix_r + DIX_W'(1'b1);
        end else begin
            dix_next_s = dix_r;
        end
        lane_sel_s = head_next_s[dix_next_s * LANE_W +: LANE_W];
`ifdef SHA3_DIGEST_BYTESWAP_EN
        word_next_s = byteswap64(lane_sel_s);
`else
        word_next_s = lane_sel_s;
`endif
    end

    // Control FSM and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            dix_r      <= '0;
            dout_r     <= '0;
            tagout_r   <= '0;
            pushout_r  <= 1'b0;
            lastout_r  <= 1'b0;
            stopout_r  <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (wr_en_s) begin
                        state_r <= ST_SEND;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (pop_s && (count_s == CNT_W'(1'b1)) && !wr_en_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_SEND;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
            dix_r      <= dix_next_s;
            pushout_r  <= send_next_s;
            lastout_r  <= send_next_s && (dix_next_s == DIX_LAST);
            dout_r     <= send_next_s ? word_next_s : '0;
            tagout_r   <= send_next_s ? head_next_s[DIGEST_LANES * LANE_W +: TAG_W] : '0;
            stopout_r  <= (count_next_s == CNT_W'(DEPTH));
            overflow_r <= overflow_r | drop_s;
        end
    end

    assign bus.dout     = dout_r;
    assign bus.dix      = dix_r;
    assign bus.tagout   = tagout_r;
    assign bus.pushout  = pushout_r;
    assign bus.lastout  = lastout_r;
    assign bus.stopout  = stopout_r;
    assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_sha3_digest_serializer.sv
// Self-checking bench for sha3_digest_serializer: directed scenarios with
// literal expectations plus randomized traffic compared every cycle against
// a queue-based model of the digest buffer.
module tb_sha3_digest_serializer;
    import sha3_digest_serializer_pkg::*;

    localparam int DEPTH = 2;
    localparam int NL    = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    sha3_digest_serializer_if #(.LANE_W(64), .DIX_W(2), .TAG_W(8), .STATE_W(1600)) bus ();

    sha3_digest_serializer #(
        .LANE_W(64), .DIGEST_LANES(NL), .TAG_W(8), .DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]   tag;
        logic [255:0] lanes;
    } dig_t;

    dig_t q[$];
    int   widx;
    bit   ovf;
    bit   check_en;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] out_word(input logic [63:0] lane);
`ifdef SHA3_DIGEST_BYTESWAP_EN
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[63 - 8 * b -: 8] = lane[8 * b +: 8];
        return r;
`else
        return lane;
`endif
    endfunction

    function automatic logic [1599:0] mk_state(input logic [63:0] base);
        logic [1599:0] s;
        for (int i = 0; i < 25; i++) s[i * 64 +: 64] = {$urandom, $urandom};
        for (int x = 0; x < NL; x++) s[x * 64 +: 64] = base + 64'(x);
        return s;
    endfunction

    // Compare process: DUT outputs against the model, away from the active edge.
    always @(negedge clk) begin
        dig_t h;
        if (check_en) begin
            chk("m_pushout", 64'(bus.pushout), 64'(q.size() > 0));
            chk("m_stopout", 64'(bus.stopout), 64'(q.size() == DEPTH));
            chk("m_overflow", 64'(bus.overflow), 64'(ovf));
            if (q.size() > 0) begin
                h = q[0];
                chk("m_dout", bus.dout, out_word(h.lanes[widx * 64 +: 64]));
                chk("m_dix", 64'(bus.dix), 64'(widx));
                chk("m_tagout", 64'(bus.tagout), 64'(h.tag));
                chk("m_lastout", 64'(bus.lastout), 64'(widx == NL - 1));
            end
        end
    end

    // One clock: drive inputs, update the model after the edge, return at negedge+1.
    task automatic cycle(input bit pin, input bit stall, input logic [1599:0] d, input logic [7:0] t);
        bit   accept;
        bit   pop;
        bit   full;
        dig_t e;
        bus.pushin = pin;
        bus.stopin = stall;
        bus.din    = d;
        bus.tagin  = t;
        @(posedge clk);
        #1;
        full   = (q.size() == DEPTH);
        accept = (q.size() > 0) && !stall;
        pop    = accept && (widx == NL - 1);
        if (pop) begin
            e = q.pop_front();
            widx = 0;
        end else if (accept) begin
            widx++;
        end
        if (pin && (!full || pop)) begin
            e.tag   = t;
            e.lanes = d[255:0];
            q.push_back(e);
        end else if (pin) begin
            ovf = 1'b1;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 8'h00);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pushout"}, 64'(bus.pushout), 64'h0);
        chk({tag, "_lastout"}, 64'(bus.lastout), 64'h0);
        chk({tag, "_stopout"}, 64'(bus.stopout), 64'h0);
        chk({tag, "_overflow"}, 64'(bus.overflow), 64'h0);
        chk({tag, "_dout"}, bus.dout, 64'h0);
        chk({tag, "_tagout"}, 64'(bus.tagout), 64'h0);
        chk({tag, "_dix"}, 64'(bus.dix), 64'h0);
    endtask

    initial begin
        logic [1599:0] s;
        logic [1599:0] sb;
        int            n;
        logic [7:0]    tags[2];

        bus.pushin = 1'b0;
        bus.stopin = 1'b0;
        bus.din    = '0;
        bus.tagin  = 8'h00;
        check_en   = 1'b0;
        widx       = 0;
        ovf        = 1'b0;
        q.delete();

        // Reset state
        #12;
        chk_all_zero("rst");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_en = 1'b1;
        idle(2);

        // Single unstalled digest
        s = mk_state(64'h0123456789ABCDE0);
        cycle(1'b1, 1'b0, s, 8'h5A);
        for (int i = 0; i < NL; i++) begin
            chk("t2_dout", bus.dout, out_word(64'h0123456789ABCDE0 + 64'(i)));
            chk("t2_dix", 64'(bus.dix), 64'(i));
            chk("t2_tag", 64'(bus.tagout), 64'h5A);
            chk("t2_last", 64'(bus.lastout), 64'(i == NL - 1));
            cycle(1'b0, 1'b0, '0, 8'h00);
        end
        chk("t2_done", 64'(bus.pushout), 64'h0);

        // Output byte order
        s = mk_state(64'h0011223344556677);
        cycle(1'b1, 1'b0, s, 8'h01);
`ifdef SHA3_DIGEST_BYTESWAP_EN
        chk("t6_swap", bus.dout, 64'h7766554433221100);
`else
        chk("t6_noswap", bus.dout, 64'h0011223344556677);
`endif
        idle(5);

        // Stall on word 1 for three cycles
        s = mk_state(64'h0123456789ABCDE0);
        cycle(1'b1, 1'b0, s, 8'hC3);
        chk("t3_w0", bus.dout, out_word(64'h0123456789ABCDE0));
        cycle(1'b0, 1'b0, '0, 8'h00);
        chk("t3_w1", bus.dout, out_word(64'h0123456789ABCDE1));
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, '0, 8'h00);
            chk("t3_hold", bus.dout, out_word(64'h0123456789ABCDE1));
            chk("t3_hold_dix", 64'(bus.dix), 64'h1);
        end
        cycle(1'b0, 1'b0, '0, 8'h00);
        chk("t3_w2", bus.dout, out_word(64'h0123456789ABCDE2));
        cycle(1'b0, 1'b0, '0, 8'h00);
        chk("t3_w3", bus.dout, out_word(64'h0123456789ABCDE3));
        chk("t3_last", 64'(bus.lastout), 64'h1);
        idle(3);

        // Fill under stall, drop the third push
        cycle(1'b1, 1'b1, mk_state(64'hA000), 8'h11);
        chk("t4_stop1", 64'(bus.stopout), 64'h0);
        cycle(1'b1, 1'b1, mk_state(64'hB000), 8'h22);
        chk("t4_stop2", 64'(bus.stopout), 64'h1);
        cycle(1'b1, 1'b1, mk_state(64'hC000), 8'h33);
        chk("t4_ovf", 64'(bus.overflow), 64'h1);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 1'b0, '0, 8'h00);
            if (bus.pushout && bus.lastout) begin
                if (n < 2) tags[n] = bus.tagout;
                n++;
            end
        end
        chk("t4_digests", 64'(n), 64'h2);
        chk("t4_tag0", 64'(tags[0]), 64'h11);
        chk("t4_tag1", 64'(tags[1]), 64'h22);

        // Reset in the middle of a digest
        cycle(1'b1, 1'b0, mk_state(64'hD000), 8'h44);
        cycle(1'b0, 1'b0, '0, 8'h00);
        #2;
        check_en = 1'b0;
        reset    = 1'b0;
        #1;
        chk_all_zero("t1");
        q.delete();
        widx = 0;
        ovf  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_en = 1'b1;
        idle(3);
        chk("t1_idle", 64'(bus.pushout), 64'h0);

        // Push on the pop cycle of a full buffer
        cycle(1'b1, 1'b1, mk_state(64'hA100), 8'hA1);
        sb = mk_state(64'hB200);
        cycle(1'b1, 1'b1, sb, 8'hB2);
        chk("t5_full", 64'(bus.stopout), 64'h1);
        idle(3);
        chk("t5_last", 64'(bus.lastout), 64'h1);
        cycle(1'b1, 1'b0, mk_state(64'hC300), 8'hC3);
        chk("t5_stop", 64'(bus.stopout), 64'h1);
        chk("t5_ovf", 64'(bus.overflow), 64'h0);
        chk("t5_next", bus.dout, out_word(64'hB200));
        chk("t5_tag", 64'(bus.tagout), 64'hB2);
        idle(10);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3),
                  mk_state({$urandom, $urandom}), 8'($urandom));
        end
        idle(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
